// File: rtl/sensors_average_pkg.sv
// sensors_average_pkg: shared state encoding, widths and rounding helper for sensors_average.
package sensors_average_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;
  localparam int SUM_W = 16;
  localparam int CNT_W = 8;
  localparam int DIV_STEPS = 16;
  // Round half up on q + r/n, saturating at 255; zero sensors yields 0.
  function automatic logic [7:0] round_avg(input logic [SUM_W-1:0] q, input logic [SUM_W-1:0] r,
                                           input logic [CNT_W-1:0] n);
    logic [SUM_W:0] t;
    t = {1'b0, q} + (SUM_W+1)'(({1'b0, r} << 1) >= (SUM_W+1)'(n));
    return (n == '0) ? 8'd0 : ((t > (SUM_W+1)'(255)) ? 8'hFF : t[7:0]);
  endfunction
endpackage

// File: rtl/sensors_average_if.sv
// sensors_average_if: start/snapshot inputs and held result outputs of sensors_average.
interface sensors_average_if
  import sensors_average_pkg::*;
#(
  parameter int NR_SENSORS = 8,
  parameter int SENSOR_W = 8
);
  logic                           start_i;
  logic [NR_SENSORS*SENSOR_W-1:0] sensors_data_i;
  logic [NR_SENSORS-1:0]          sensors_en_i;
  logic [SUM_W-1:0]               temp_Q_o;
  logic [SUM_W-1:0]               temp_R_o;
  logic [CNT_W-1:0]               active_sensors_nr_o;
  logic [7:0]                     rounded_o;
  logic                           valid_o;
  logic                           busy_o;
  modport master (
    output start_i, sensors_data_i, sensors_en_i,
    input  temp_Q_o, temp_R_o, active_sensors_nr_o, rounded_o, valid_o, busy_o
  );
  modport slave (
    input  start_i, sensors_data_i, sensors_en_i,
    output temp_Q_o, temp_R_o, active_sensors_nr_o, rounded_o, valid_o, busy_o
  );
endinterface

// File: rtl/sensors_average_serial_divider.sv
// serial_divider: 16-step restoring divider, one quotient bit per cycle MSB first.
// quotient_o/remainder_o carry the step being taken, so they are final while done_o is high.
module serial_divider
  import sensors_average_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [SUM_W-1:0] divisor_i,
  output logic [SUM_W-1:0] quotient_o,
  output logic [SUM_W-1:0] remainder_o,
  output logic             done_o
);
  logic [SUM_W-1:0] r_quo, r_rem, r_div;
  logic [3:0]       r_cnt;
  logic             r_run;
  logic [SUM_W:0]   w_sh;
  logic             w_ge;
  assign w_sh        = {r_rem, r_quo[SUM_W-1]};
  assign w_ge        = w_sh >= {1'b0, r_div};
  assign quotient_o  = {r_quo[SUM_W-2:0], w_ge};
  assign remainder_o = w_ge ? SUM_W'(w_sh - {1'b0, r_div}) : w_sh[SUM_W-1:0];
  assign done_o      = r_run && (r_cnt == 4'(DIV_STEPS-1));
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start_i) begin
      r_quo <= dividend_i;
      r_rem <= '0;
      r_div <= divisor_i;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_quo <= quotient_o;
      r_rem <= remainder_o;
      r_cnt <= r_cnt + 4'd1;
      r_run <= !done_o;
    end
  end
endmodule

// File: rtl/sensors_average.sv
// sensors_average: snapshot enabled sensors, accumulate one per cycle, then serially divide by the count.
// Optional SENSORS_AVERAGE_ROUND_EN builds the rounded_o output; otherwise rounded_o is tied to 0.
module sensors_average
  import sensors_average_pkg::*;
#(
  parameter int NR_SENSORS = 8,
  parameter int SENSOR_W = 8
)(
  input logic clk_i,
  input logic rst_n_i,
  sensors_average_if.slave bus
);
  localparam int IDX_W = 4;
  state_t                         r_state;
  logic [NR_SENSORS*SENSOR_W-1:0] r_snap_data;
  logic [NR_SENSORS-1:0]          r_snap_en;
  logic [SUM_W-1:0]               r_sum, r_q, r_r;
  logic [CNT_W-1:0]               r_cnt, r_nr;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_valid, r_busy;
  logic [SENSOR_W-1:0]            w_rd;
  logic                           w_on, w_last, w_acc_zero, w_div_start, w_div_done;
  logic [SUM_W-1:0]               w_sum_n, w_div_q, w_div_r;
  logic [CNT_W-1:0]               w_cnt_n;
  assign w_rd        = SENSOR_W'(r_snap_data >> (r_idx * SENSOR_W));
  assign w_on        = 1'(r_snap_en >> r_idx);
  assign w_sum_n     = r_sum + (w_on ? SUM_W'(w_rd) : '0);
  assign w_cnt_n     = r_cnt + CNT_W'(w_on);
  assign w_last      = r_idx == IDX_W'(NR_SENSORS-1);
  assign w_acc_zero  = (r_state == ACCUM) && w_last && (w_cnt_n == '0);
  assign w_div_start = (r_state == ACCUM) && w_last && (w_cnt_n != '0);
  serial_divider u_div (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (w_div_start),
    .dividend_i  (w_sum_n),
    .divisor_i   (SUM_W'(w_cnt_n)),
    .quotient_o  (w_div_q),
    .remainder_o (w_div_r),
    .done_o      (w_div_done)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_snap_data <= '0;
      r_snap_en   <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_nr        <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.start_i) begin
          r_snap_data <= bus.sensors_data_i;
          r_snap_en   <= bus.sensors_en_i;
          r_sum       <= '0;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_valid     <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= ACCUM;
        end
        ACCUM: begin
          r_sum <= w_sum_n;
          r_cnt <= w_cnt_n;
          r_idx <= r_idx + IDX_W'(1);
          if (w_acc_zero) begin
            r_q     <= '0;
            r_r     <= '0;
            r_nr    <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else if (w_last) begin
            r_state <= DIV;
          end
        end
        DIV: if (w_div_done) begin
          r_q     <= w_div_q;
          r_r     <= w_div_r;
          r_nr    <= r_cnt;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef SENSORS_AVERAGE_ROUND_EN
  logic [7:0] r_rnd;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || w_acc_zero) r_rnd <= '0;
    else if (r_state == DIV && w_div_done) r_rnd <= round_avg(w_div_q, w_div_r, r_cnt);
  end
  assign bus.rounded_o = r_rnd;
`else
  assign bus.rounded_o = '0;
`endif
  assign bus.temp_Q_o            = r_q;
  assign bus.temp_R_o            = r_r;
  assign bus.active_sensors_nr_o = r_nr;
  assign bus.valid_o             = r_valid;
  assign bus.busy_o              = r_busy;
endmodule
